// File: rtl/mem_loader.sv
// mem_loader: loads a big-endian (addr, count, words[, chk]) byte frame into the processor's 2R/1W memory.
// Latency: one w_en pulse 1 cycle after each word's LO byte is accepted; at most one write every 2 cycles.
// Backpressure: valid/ready on the byte stream; in_ready is high only in the receive states, never in IDLE/DONE/ERR.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset (0 = reset)
//   start               one-cycle pulse, arms a new load when idle (ignored otherwise)
//   in_data/in_valid    stream byte and its valid
//   in_ready            a byte is accepted on a rising edge when in_valid && in_ready
//   w_addr/w_data/w_en  memory write port, one-cycle w_en pulse per word
//   cpu_hold            keeps the processor in reset while a load is in progress or after an aborted load
//   done / error        sticky status of the last load, cleared by the next start
//
// Build option: define MEM_LOADER_CHECKSUM_EN to append a CHK byte (XOR of every header and data
// byte) to the frame; a mismatch ends the load in ERR. Without it, completion goes straight to DONE.

module mem_loader #(
    parameter int N_ELEMENTS = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_en,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // Address and count arrive as 16-bit frame fields; the end-of-range sum carries one
    // extra bit so start_addr + count can never wrap past the limit.
    localparam int          FW      = 16;
    localparam logic [FW:0] N_LIMIT = (FW + 1)'(N_ELEMENTS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_DONE,
        S_ERR
`ifdef MEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    // Where a load goes once the last data word (or an empty count) has been taken.
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t        state;
    state_t        state_nxt;

    logic [FW-1:0] addr_q;     // start address, then current write address
    logic [FW-1:0] cnt_q;      // word count, then words remaining
    logic [7:0]    hi_q;       // high byte of the word being assembled
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q;     // running XOR of all accepted bytes before CHK
`endif

    logic          accept;
    logic [FW-1:0] cnt_full;   // count as it will be once CNT_LO is taken
    logic [FW:0]   end_addr;
    logic          range_bad;

    assign accept    = in_valid && in_ready;
    assign cnt_full  = {cnt_q[FW-1:8], in_data};
    assign end_addr  = {1'b0, addr_q} + {1'b0, cnt_full};
    assign range_bad = (end_addr > N_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and stream ready
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR_HI;
                end
            end
            S_ADDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_ADDR_LO;
            end
            S_ADDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (range_bad) begin
                        state_nxt = S_ERR;
                    end else if (cnt_full == '0) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // cnt_q still holds the count before this word is retired
                    state_nxt = (cnt_q == FW'(1)) ? S_FINISH : S_DATA_HI;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, write port and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            w_en     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            w_en <= 1'b0;

            if ((state == S_IDLE) && start) begin
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                addr_q   <= '0;
                cnt_q    <= '0;
            end

            if (accept) begin
                unique case (state)
                    S_ADDR_HI: addr_q <= {in_data, 8'h00};
                    S_ADDR_LO: addr_q <= {addr_q[FW-1:8], in_data};
                    S_CNT_HI:  cnt_q  <= {in_data, 8'h00};
                    S_CNT_LO:  cnt_q  <= cnt_full;
                    S_DATA_HI: hi_q   <= in_data;
                    S_DATA_LO: begin
                        w_en   <= 1'b1;
                        w_addr <= ADDR_WIDTH'(addr_q);
                        w_data <= DATA_WIDTH'({hi_q, in_data});
                        addr_q <= addr_q + FW'(1);
                        cnt_q  <= cnt_q - FW'(1);
                    end
                    default: ;
                endcase
            end

            // Flags change on the edge that enters DONE/ERR so they are visible in that state.
            // cpu_hold is deliberately left set on ERR: a partial image must not run.
            if (state_nxt == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (state_nxt == S_ERR) begin
                error <= 1'b1;
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            csum_q <= '0;
        end else if (accept && (state != S_CHK)) begin
            csum_q <= csum_q ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed frames with hand-computed writes and status for mem_loader.
// Latency: writes are captured on the falling edge while w_en is high.
// Backpressure: bytes are held with in_valid until in_ready, with optional idle gaps.

module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        w_en;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  bq[$];
    logic [15:0] wa[$];
    logic [15:0] wd[$];

    mem_loader #(
        .N_ELEMENTS(128),
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_en     (w_en),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_en) begin
            wa.push_back(w_addr);
            wd.push_back(w_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the rising edge that transferred the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_q(input int maxgap);
        foreach (bq[i]) send_byte(bq[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    function automatic logic [7:0] xor_q();
        logic [7:0] x = 8'h00;
        foreach (bq[i]) x ^= bq[i];
        return x;
    endfunction

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    task automatic chk_status(input string tag, input logic [4:0] exp);
        chk(tag, 32'({in_ready, w_en, cpu_hold, done, error}), 32'(exp));
    endtask

    initial begin
        logic [15:0] exp_d[4];
        exp_d[0] = 16'h1357;
        exp_d[1] = 16'h2468;
        exp_d[2] = 16'h9ABC;
        exp_d[3] = 16'hDEF0;

        // ---------------- reset, idle with in_valid held high ----------------
        #3 rst = 1'b0;
        #2;
        chk_status("reset_flags", 5'b00000);
        chk("reset_waddr", 32'(w_addr), 32'h0);
        chk("reset_wdata", 32'(w_data), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_status("idle_flags", 5'b00000);
        end
        in_valid = 1'b0;
        chk("idle_no_writes", 32'(wa.size()), 32'd0);

        // ---------------- basic two-word load ----------------
        clear_writes();
        pulse_start();
        chk_status("load_armed", 5'b10100);
        bq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_q(0);
        chk("lat_wen", 32'(w_en), 32'd1);
        chk("lat_waddr", 32'(w_addr), 32'h0011);
        chk("lat_wdata", 32'(w_data), 32'hABCD);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(xor_q(), 0);
`endif
        repeat (3) @(negedge clk);
        chk("basic_nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("basic_a0", 32'(wa[0]), 32'h0010);
            chk("basic_d0", 32'(wd[0]), 32'h1234);
            chk("basic_a1", 32'(wa[1]), 32'h0011);
            chk("basic_d1", 32'(wd[1]), 32'hABCD);
        end
        chk_status("basic_done", 5'b00010);

        // ---------------- range error: 0x7E + 3 > 128 ----------------
        clear_writes();
        pulse_start();
        chk_status("err_armed_clears_done", 5'b10100);
        bq = '{8'h00, 8'h7E, 8'h00, 8'h03};
        send_q(0);
        chk_status("err_after_cnt", 5'b00101);
        repeat (5) @(negedge clk);
        chk_status("err_sticky", 5'b00101);
        chk("err_no_writes", 32'(wa.size()), 32'd0);

        // ---------------- range boundary: 0x7E + 2 == 128 fits ----------------
        clear_writes();
        pulse_start();
        chk_status("edge_armed_clears_err", 5'b10100);
        bq = '{8'h00, 8'h7E, 8'h00, 8'h02, 8'hC0, 8'h01, 8'hC0, 8'h02};
`ifdef MEM_LOADER_CHECKSUM_EN
        bq.push_back(xor_q());
`endif
        send_q(0);
        repeat (3) @(negedge clk);
        chk("edge_nwr", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("edge_a1", 32'(wa[1]), 32'h007F);
            chk("edge_d1", 32'(wd[1]), 32'hC002);
        end
        chk_status("edge_done", 5'b00010);

        // ---------------- zero count completes with no writes ----------------
        clear_writes();
        pulse_start();
        bq = '{8'h00, 8'h05, 8'h00, 8'h00};
`ifdef MEM_LOADER_CHECKSUM_EN
        bq.push_back(xor_q());
`endif
        send_q(0);
        repeat (3) @(negedge clk);
        chk("zero_nwr", 32'(wa.size()), 32'd0);
        chk_status("zero_done", 5'b00010);

        // ---------------- gappy 4-word load with a stray start ----------------
        clear_writes();
        pulse_start();
        bq = '{8'h00, 8'h00, 8'h00, 8'h04};
        for (int i = 0; i < 4; i++) begin
            bq.push_back(exp_d[i][15:8]);
            bq.push_back(exp_d[i][7:0]);
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        bq.push_back(xor_q());
`endif
        foreach (bq[i]) begin
            if (i == 7) pulse_start();
            send_byte(bq[i], int'($urandom_range(3, 0)));
        end
        repeat (3) @(negedge clk);
        chk("gap_nwr", 32'(wa.size()), 32'd4);
        if (wa.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("gap_addr", 32'(wa[i]), 32'(i));
                chk("gap_data", 32'(wd[i]), 32'(exp_d[i]));
            end
        end
        chk_status("gap_done", 5'b00010);

        // ---------------- reset mid-load ----------------
        clear_writes();
        pulse_start();
        bq = '{8'h00, 8'h20, 8'h00, 8'h03, 8'h11, 8'h22};
        send_q(0);
        chk("mid_wen_before_rst", 32'(w_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_status("mid_rst_flags", 5'b00000);
        chk("mid_rst_waddr", 32'(w_addr), 32'h0);
        chk("mid_rst_wdata", 32'(w_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        clear_writes();
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (10) @(negedge clk);
        chk("mid_no_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk("mid_no_writes", 32'(wa.size()), 32'd0);

        pulse_start();
        bq = '{8'h00, 8'h05, 8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef MEM_LOADER_CHECKSUM_EN
        bq.push_back(xor_q());
`endif
        send_q(1);
        repeat (3) @(negedge clk);
        chk("fresh_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("fresh_a0", 32'(wa[0]), 32'h0005);
            chk("fresh_d0", 32'(wd[0]), 32'hBEEF);
        end
        chk_status("fresh_done", 5'b00010);

`ifdef MEM_LOADER_CHECKSUM_EN
        // ---------------- bad checksum: correct value would be 0x04 ----------------
        clear_writes();
        pulse_start();
        bq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00};
        send_q(0);
        chk_status("csum_bad_flags", 5'b00101);
        repeat (3) @(negedge clk);
        chk("csum_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            chk("csum_a0", 32'(wa[0]), 32'h0000);
            chk("csum_d0", 32'(wd[0]), 32'h0005);
        end
        chk_status("csum_sticky", 5'b00101);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
